ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to send,
// shifts one byte with odd parity on device clock edges and checks the line ack.
module ps2_host_tx #(
    parameter int CLK_HOLD   = 5000,
    parameter int DATA_SETUP = 250,
    parameter int TIMEOUT    = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int HOLD_W  = $clog2(CLK_HOLD + 1);
    localparam int SETUP_W = $clog2(DATA_SETUP + 1);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(CLK_HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(CLK_HOLD);
    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(DATA_SETUP - 1);
    localparam logic [SETUP_W-1:0] SETUP_MAX  = SETUP_W'(DATA_SETUP);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]   TMO_MAX    = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, SETUP, REQ, SHIFT, ACK, RELEASE
    } state_t;

    state_t              state_reg, state_next;
    logic [9:0]          frame_reg, frame_next;
    logic [3:0]          bit_cnt_reg, bit_cnt_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [SETUP_W-1:0]  setup_cnt_reg, setup_cnt_next;
    logic [TMO_W-1:0]    tmo_cnt_reg, tmo_cnt_next;
    logic                dat_bit_reg, dat_bit_next;
    logic                done_reg, done_next;
    logic                error_reg, error_next;
    logic                clk_meta_reg, clk_sync_reg, clk_prev_reg;
    logic                dat_meta_reg, dat_sync_reg;
    logic                clk_fall;

    assign clk_fall = clk_prev_reg & ~clk_sync_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg     <= IDLE;
            frame_reg     <= '0;
            bit_cnt_reg   <= '0;
            hold_cnt_reg  <= '0;
            setup_cnt_reg <= '0;
            tmo_cnt_reg   <= '0;
            dat_bit_reg   <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            clk_meta_reg  <= 1'b1;
            clk_sync_reg  <= 1'b1;
            clk_prev_reg  <= 1'b1;
            dat_meta_reg  <= 1'b1;
            dat_sync_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            frame_reg     <= frame_next;
            bit_cnt_reg   <= bit_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
            setup_cnt_reg <= setup_cnt_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            dat_bit_reg   <= dat_bit_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
            clk_meta_reg  <= ps2_clk_in;
            clk_sync_reg  <= clk_meta_reg;
            clk_prev_reg  <= clk_sync_reg;
            dat_meta_reg  <= ps2_dat_in;
            dat_sync_reg  <= dat_meta_reg;
        end
    end

    always_comb begin
        state_next     = state_reg;
        frame_next     = frame_reg;
        bit_cnt_next   = bit_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        setup_cnt_next = setup_cnt_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        dat_bit_next   = dat_bit_reg;
        done_next      = 1'b0;
        error_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                dat_bit_next = 1'b0;
                if (tx_start) begin
                    frame_next    = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_next  = '0;
                    hold_cnt_next = '0;
                    state_next    = INHIBIT;
                end
            end
            INHIBIT: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    setup_cnt_next = '0;
                    state_next     = SETUP;
                end else if (hold_cnt_reg != HOLD_MAX) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            SETUP: begin
                if (setup_cnt_reg == SETUP_LAST) begin
                    tmo_cnt_next = '0;
                    bit_cnt_next = '0;
                    dat_bit_next = 1'b1;    // keep the start bit low after clock release
                    state_next   = REQ;
                end else if (setup_cnt_reg != SETUP_MAX) begin
                    setup_cnt_next = setup_cnt_reg + 1'b1;
                end
            end
            default: begin
                // REQ, SHIFT, ACK, RELEASE: the device owns the clock, bounded by the timeout
                if (tmo_cnt_reg == TMO_LAST) begin
                    error_next   = 1'b1;
                    dat_bit_next = 1'b0;
                    state_next   = IDLE;
                end else begin
                    if (tmo_cnt_reg != TMO_MAX) tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    case (state_reg)
                        REQ, SHIFT: begin
                            if (clk_fall) begin
                                dat_bit_next = ~frame_reg[bit_cnt_reg];
                                if (bit_cnt_reg != 4'd10) bit_cnt_next = bit_cnt_reg + 1'b1;
                                state_next = (bit_cnt_reg == 4'd9) ? ACK : SHIFT;
                            end
                        end
                        ACK: begin
                            dat_bit_next = 1'b0;
                            if (clk_fall) begin
                                if (!dat_sync_reg) begin
                                    state_next = RELEASE;
                                end else begin
                                    error_next = 1'b1;
                                    state_next = IDLE;
                                end
                            end
                        end
                        RELEASE: begin
                            if (clk_sync_reg && dat_sync_reg) begin
                                done_next  = 1'b1;
                                state_next = IDLE;
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
        endcase
    end

    assign ps2_clk_oe = (state_reg == INHIBIT) || (state_reg == SETUP);
    assign ps2_dat_oe = (state_reg == SETUP) ||
                        (((state_reg == REQ) || (state_reg == SHIFT)) && dat_bit_reg);
    assign tx_busy    = (state_reg != IDLE);
    assign tx_done    = done_reg;
    assign tx_error   = error_reg;
endmodule
